// File: rtl/ram_frame_reader_pkg.sv
// Shared constants and types for the ping-pong frame reader.
package ram_frame_reader_pkg;

   // Frame geometry: 8 channels x 3 bytes, two frame buffers.
   localparam int FRAME_BYTES = 24;
   localparam int NUM_BUF     = 2;
   localparam int BYTE_W      = 8;
   localparam int RAM_DEPTH   = NUM_BUF * FRAME_BYTES;

   // Derived widths. The write pointer must reach FRAME_BYTES + 1 (overlong frame marker).
   localparam int ADDR_W   = $clog2(RAM_DEPTH);
   localparam int WR_PTR_W = $clog2(FRAME_BYTES + 2);
   localparam int RD_PTR_W = $clog2(FRAME_BYTES);

   // Reader FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/ram_frame_reader_if.sv
// Writer-side and host-side signals of the frame reader, grouped in one bundle.
interface ram_frame_reader_if;
   import ram_frame_reader_pkg::*;

   logic              ram_wr_en;
   logic              ram_write_cover;
   logic [BYTE_W-1:0] ramdata;
   logic              no_wr_when_rd;
   logic [BYTE_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eof;
   logic              frame_err;
   logic              ovf_err;

   // The frame reader itself.
   modport slave (
      input  ram_wr_en, ram_write_cover, ramdata, out_ready,
      output no_wr_when_rd, out_data, out_valid, out_sof, out_eof, frame_err, ovf_err
   );

   // The writer plus host that drive the reader.
   modport master (
      output ram_wr_en, ram_write_cover, ramdata, out_ready,
      input  no_wr_when_rd, out_data, out_valid, out_sof, out_eof, frame_err, ovf_err
   );

endinterface

// File: rtl/ram_frame_reader_frame_buf_ram.sv
// Simple dual-port synchronous RAM holding both frame buffers: one write port,
// one read port with a registered output that holds until the next read.
module frame_buf_ram #(
   parameter int DEPTH  = 48,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read port; storage carries no reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_frame_reader.sv
// Captures writer frames into two ping-pong buffers and streams committed
// frames, byte by byte and in arrival order, over a valid/ready host port.
module ram_frame_reader
   import ram_frame_reader_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   ram_frame_reader_if.slave bus
);

   // Writer side state
   logic                wr_en_q;
   logic                cover_q;
   logic                active_q, active_d;
   logic [WR_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic                fill_q, fill_d;
   logic [NUM_BUF-1:0]  full_q, full_d;
   logic                no_wr_q;
   logic                frame_err_q, frame_err_d;
   logic                ovf_err_q, ovf_err_d;

   // Reader side state
   rd_state_e           state_q, state_d;
   logic [RD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic                drain_q, drain_d;

   logic                wr_strobe, cover_rise, cover_fall;
   logic                commit, drain_done;
   logic                ram_we, ram_re;
   logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
   logic [BYTE_W-1:0]   ram_rdata;

   // Buffer sel occupies RAM words [sel*FRAME_BYTES, sel*FRAME_BYTES + FRAME_BYTES-1].
   function automatic logic [ADDR_W-1:0] buf_addr(input logic sel, input logic [WR_PTR_W-1:0] ptr);
      logic [ADDR_W-1:0] base;
      base = sel ? ADDR_W'(FRAME_BYTES) : '0;
      return base + ADDR_W'(ptr);
   endfunction

   assign wr_strobe  = wr_en_q & ~bus.ram_wr_en;
   assign cover_rise = ~cover_q & bus.ram_write_cover;
   assign cover_fall = cover_q & ~bus.ram_write_cover;

   // Writer: open/close frames, store bytes, detect short/long and overflow frames.
   always_comb begin
      active_d    = active_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      frame_err_d = 1'b0;
      ovf_err_d   = 1'b0;
      commit      = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = buf_addr(fill_q, wr_ptr_q);
      if (cover_rise) begin
         if (no_wr_q) begin
            // Both buffers are occupied: the whole frame is ignored.
            ovf_err_d = 1'b1;
            active_d  = 1'b0;
         end else begin
            active_d = 1'b1;
            wr_ptr_d = '0;
         end
      end else if (cover_fall) begin
         if (active_q) begin
            active_d = 1'b0;
            if (wr_ptr_q == WR_PTR_W'(FRAME_BYTES)) begin
               commit = 1'b1;
               fill_d = ~fill_q;
            end else begin
               frame_err_d = 1'b1;
            end
         end
      end else if (wr_strobe && active_q) begin
         if (wr_ptr_q < WR_PTR_W'(FRAME_BYTES)) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end else begin
            // Excess bytes are dropped; the pointer parks past the end so the close fails.
            wr_ptr_d = WR_PTR_W'(FRAME_BYTES + 1);
         end
      end
   end

   // Reader FSM: fetch one byte, present it, advance on handshake.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      drain_d    = drain_q;
      ram_re     = 1'b0;
      drain_done = 1'b0;
      ram_raddr  = buf_addr(drain_q, WR_PTR_W'(rd_ptr_q));
      case (state_q)
         ST_IDLE: begin
            if (full_q[drain_q]) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            ram_re  = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (bus.out_ready) begin
               if (rd_ptr_q == RD_PTR_W'(FRAME_BYTES - 1)) begin
                  drain_done = 1'b1;
                  drain_d    = ~drain_q;
                  rd_ptr_d   = '0;
                  state_d    = ST_IDLE;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  state_d  = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Full flags: commit and drain-complete touch different buffers, so both apply.
   always_comb begin
      full_d = full_q;
      if (drain_done) begin
         full_d[drain_q] = 1'b0;
      end
      if (commit) begin
         full_d[fill_q] = 1'b1;
      end
   end

   // State registers; cover_q resets high so a cover already high at release is not a new frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_q     <= 1'b1;
         cover_q     <= 1'b1;
         active_q    <= 1'b0;
         wr_ptr_q    <= '0;
         fill_q      <= 1'b0;
         full_q      <= '0;
         no_wr_q     <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_err_q   <= 1'b0;
         state_q     <= ST_IDLE;
         rd_ptr_q    <= '0;
         drain_q     <= 1'b0;
      end else begin
         wr_en_q     <= bus.ram_wr_en;
         cover_q     <= bus.ram_write_cover;
         active_q    <= active_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         full_q      <= full_d;
         no_wr_q     <= &full_d;
         frame_err_q <= frame_err_d;
         ovf_err_q   <= ovf_err_d;
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         drain_q     <= drain_d;
      end
   end

   frame_buf_ram #(
      .DEPTH  (RAM_DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (BYTE_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (bus.ramdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // RAM output register is not reset, so data is masked outside SEND.
   assign bus.out_valid     = (state_q == ST_SEND);
   assign bus.out_data      = bus.out_valid ? ram_rdata : '0;
   assign bus.out_sof       = bus.out_valid && (rd_ptr_q == '0);
   assign bus.out_eof       = bus.out_valid && (rd_ptr_q == RD_PTR_W'(FRAME_BYTES - 1));
   assign bus.no_wr_when_rd = no_wr_q;
   assign bus.frame_err     = frame_err_q;
   assign bus.ovf_err       = ovf_err_q;

endmodule
